// File: rtl/decode_stage.sv
// Instruction-decode stage owning the PC: fetch handshake, R/I-type decode, jumps, redirects, HALT.
// Optional DECODE_ILLEGAL_TRAP_EN: unknown encodings set sticky illegal and halt instead of decoding as NOP.
module decode_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] fetch_pc,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [PC_W-1:0] dec_pc,
  output logic [4:0]      dec_rs,
  output logic [4:0]      dec_rt,
  output logic [4:0]      dec_rd,
  output logic [31:0]     dec_imm,
  output logic [2:0]      dec_alu_ctrl,
  output logic            dec_reg_write,
  output logic            dec_mem_read,
  output logic            dec_mem_write,
  output logic            dec_branch,
  output logic            dec_use_imm,
  output logic            halted,
  output logic            illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      alu;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            use_imm;
  } bundle_t;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  bundle_t         bundle_q, bundle_d;
  logic            dec_valid_q, dec_valid_d;
  logic            illegal_q, illegal_d;

  bundle_t         dec_c;
  logic            fwd_c, is_jump_c, is_halt_c, is_bad_c, accept_c;
  logic [PC_W-1:0] pc_plus_c, jump_pc_c;
  logic [5:0]      opcode, funct;
  logic [31:0]     sext_imm, zext_imm, br_imm;
  logic            unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign sext_imm     = {{16{instr[15]}}, instr[15:0]};
  assign zext_imm     = {16'h0000, instr[15:0]};
  assign br_imm       = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_shamt = ^instr[10:6];

  assign pc_plus_c = fetch_pc_q + PC_W'(PC_STEP);

  // Jump keeps the upper PC bits of the sequential successor and replaces the low 28.
  always_comb begin
    jump_pc_c       = pc_plus_c;
    jump_pc_c[27:0] = {instr[25:0], 2'b00};
  end

  assign instr_ready = (state_q == RUN) && !redirect_valid && (!dec_valid_q || dec_ready);
  assign accept_c    = instr_valid && instr_ready;

  // Combinational decode of the presented word into a candidate bundle.
  always_comb begin
    dec_c     = '0;
    dec_c.pc  = fetch_pc_q;
    dec_c.rs  = instr[25:21];
    dec_c.rt  = instr[20:16];
    fwd_c     = 1'b1;
    is_jump_c = 1'b0;
    is_halt_c = 1'b0;
    is_bad_c  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_c.rd        = instr[15:11];
        dec_c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec_c.alu = ALU_ADD;
          FN_SUB:  dec_c.alu = ALU_SUB;
          FN_AND:  dec_c.alu = ALU_AND;
          FN_OR:   dec_c.alu = ALU_OR;
          FN_SLT:  dec_c.alu = ALU_SLT;
          default: is_bad_c = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        dec_c.rd        = instr[20:16];
        dec_c.reg_write = 1'b1;
        dec_c.use_imm   = 1'b1;
        case (opcode)
          OP_ANDI: begin dec_c.alu = ALU_AND; dec_c.imm = zext_imm; end
          OP_ORI:  begin dec_c.alu = ALU_OR;  dec_c.imm = zext_imm; end
          OP_SLTI: begin dec_c.alu = ALU_SLT; dec_c.imm = sext_imm; end
          default: begin dec_c.alu = ALU_ADD; dec_c.imm = sext_imm; end
        endcase
      end
      OP_LW: begin
        dec_c.rd        = instr[20:16];
        dec_c.imm       = sext_imm;
        dec_c.alu       = ALU_ADD;
        dec_c.mem_read  = 1'b1;
        dec_c.reg_write = 1'b1;
      end
      OP_SW: begin
        dec_c.imm       = sext_imm;
        dec_c.alu       = ALU_ADD;
        dec_c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_c.imm    = br_imm;
        dec_c.alu    = ALU_SUB;
        dec_c.branch = 1'b1;
      end
      OP_J: begin
        is_jump_c = 1'b1;
        fwd_c     = 1'b0;
      end
      OP_HALT: begin
        is_halt_c = 1'b1;
        fwd_c     = 1'b0;
      end
      default: is_bad_c = 1'b1;
    endcase
    if (is_bad_c) begin
      dec_c    = '0;
      dec_c.pc = fetch_pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
      fwd_c    = 1'b0;
`endif
    end
  end

  // Next-state: redirect beats accept; an idle consumer drains the bundle.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    bundle_d    = bundle_q;
    dec_valid_d = dec_valid_q;
    illegal_d   = illegal_q;
    if (redirect_valid) begin
      fetch_pc_d  = redirect_pc;
      dec_valid_d = 1'b0;
      state_d     = RUN;
    end else if (accept_c) begin
      dec_valid_d = fwd_c;
      if (fwd_c) begin
        bundle_d = dec_c;
      end
      if (is_halt_c) begin
        state_d = HALTED;
      end else if (is_jump_c) begin
        fetch_pc_d = jump_pc_c;
      end else begin
        fetch_pc_d = pc_plus_c;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (is_bad_c) begin
        illegal_d  = 1'b1;
        state_d    = HALTED;
        fetch_pc_d = fetch_pc_q;
      end
`endif
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      bundle_q    <= '0;
      dec_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      bundle_q    <= bundle_d;
      dec_valid_q <= dec_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign fetch_pc      = fetch_pc_q;
  assign dec_valid     = dec_valid_q;
  assign dec_pc        = bundle_q.pc;
  assign dec_rs        = bundle_q.rs;
  assign dec_rt        = bundle_q.rt;
  assign dec_rd        = bundle_q.rd;
  assign dec_imm       = bundle_q.imm;
  assign dec_alu_ctrl  = bundle_q.alu;
  assign dec_reg_write = bundle_q.reg_write;
  assign dec_mem_read  = bundle_q.mem_read;
  assign dec_mem_write = bundle_q.mem_write;
  assign dec_branch    = bundle_q.branch;
  assign dec_use_imm   = bundle_q.use_imm;
  assign halted        = (state_q == HALTED);
  assign illegal       = illegal_q;

endmodule
